// File: rtl/cook_timer.sv
// Microwave cook-time countdown: BCD MM:SS timer with pause/resume, door interlock,
// +30 s quick-add and cancel. Outputs decode registered state only.
module cook_timer #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        start,
    input  logic        pause,
    input  logic        cancel,
    input  logic        door_open,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        show_t,
    output logic        done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;

    // Only called with a nonzero time, so the minutes-tens digit never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        s1 = s1 + 4'd3;
        if (s1 >= 4'd6) begin
            s1 = s1 - 4'd6;
            if (m0 == 4'd9) begin
                m0 = 4'd0;
                if (m1 == 4'd9) return 16'h9959;
                m1 = m1 + 4'd1;
            end else begin
                m0 = m0 + 4'd1;
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    logic        load_valid;
    logic        tick;
    logic [15:0] time_dec;

    assign load_valid = (load_bcd[3:0] <= 4'd9) && (load_bcd[7:4] <= 4'd5) &&
                        (load_bcd[11:8] <= 4'd9) && (load_bcd[15:12] <= 4'd9);
    assign tick       = (state_q == S_RUN) && (presc_q == PRESC_MAX);
    assign time_dec   = bcd_dec(time_q);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = S_IDLE;
            time_d  = 16'h0000;
            presc_d = '0;
        end else if (load && load_valid && (state_q != S_RUN)) begin
            state_d = S_IDLE;
            time_d  = load_bcd;
            presc_d = '0;
        end else if (state_q == S_RUN) begin
            if (pause || door_open) begin
                state_d = S_PAUSE;
            end else begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && (time_dec == 16'h0000)) begin
                    // Natural completion wins over a same-cycle quick-add.
                    state_d = S_IDLE;
                    time_d  = 16'h0000;
                    done_d  = 1'b1;
                end else begin
                    time_d = tick ? time_dec : time_q;
                    if (start) time_d = bcd_add30(time_d);
                end
            end
        end else if (start && !pause && !door_open) begin
            if (state_q == S_PAUSE) begin
                state_d = S_RUN;
            end else if (time_q != 16'h0000) begin
                state_d = S_RUN;
                presc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            time_q  <= 16'h0000;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign time_bcd = time_q;
    assign running  = (state_q == S_RUN);
    assign show_t   = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer with a 4-cycle second: load/quick-add tables
// plus hand-written countdown, borrow, pause, door, cancel and async-reset sequences.
module tb_cook_timer;

    localparam int TPS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_bcd = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        cancel = 1'b0;
    logic        door_open = 1'b0;
    logic [15:0] time_bcd;
    logic        running;
    logic        show_t;
    logic        done;

    cook_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_bcd  (load_bcd),
        .start     (start),
        .pause     (pause),
        .cancel    (cancel),
        .door_open (door_open),
        .time_bcd  (time_bcd),
        .running   (running),
        .show_t    (show_t),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] exp;
    } vec_t;

    vec_t load_tab [10];
    vec_t add_tab  [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_time(input string name);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            check(name, {16'h0, time_bcd}, {16'h0, exp_q.pop_front()});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_bcd = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        int first_done;
        logic saw_done;

        // Load table: invalid values leave the previously loaded time in place.
        load_tab[0] = '{16'h1234, 16'h1234};
        load_tab[1] = '{16'h0060, 16'h1234};
        load_tab[2] = '{16'h00A0, 16'h1234};
        load_tab[3] = '{16'h0A00, 16'h1234};
        load_tab[4] = '{16'hA000, 16'h1234};
        load_tab[5] = '{16'h000A, 16'h1234};
        load_tab[6] = '{16'h9959, 16'h9959};
        load_tab[7] = '{16'h0059, 16'h0059};
        load_tab[8] = '{16'h5900, 16'h5900};
        load_tab[9] = '{16'h0000, 16'h0000};

        // Quick-add table: running time -> time after +30 s.
        add_tab[0] = '{16'h0045, 16'h0115};
        add_tab[1] = '{16'h9950, 16'h9959};
        add_tab[2] = '{16'h0029, 16'h0059};
        add_tab[3] = '{16'h0030, 16'h0100};
        add_tab[4] = '{16'h0959, 16'h1029};
        add_tab[5] = '{16'h9945, 16'h9959};
        add_tab[6] = '{16'h9929, 16'h9959};

        repeat (2) step();
        check("reset_time", {16'h0, time_bcd}, 32'h0);
        check("reset_running", {31'h0, running}, 32'h0);
        check("reset_show_t", {31'h0, show_t}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            do_load(load_tab[i].bcd);
            exp_q.push_back(load_tab[i].exp);
            check_time($sformatf("load_%0d", i));
            check($sformatf("load_%0d_show_t", i), {31'h0, show_t}, 32'h0);
        end

        for (int i = 0; i < 7; i++) begin
            do_load(add_tab[i].bcd);
            do_start();
            do_start();
            exp_q.push_back(add_tab[i].exp);
            check_time($sformatf("add30_%0d", i));
            check($sformatf("add30_%0d_running", i), {31'h0, running}, 32'h1);
            do_cancel();
        end

        // Basic countdown of 5 s: done after 5*TPS cycles.
        do_load(16'h0005);
        do_start();
        check("basic_running", {31'h0, running}, 32'h1);
        check("basic_show_t", {31'h0, show_t}, 32'h1);
        first_done = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 4) begin
                exp_q.push_back(16'h0004);
                check_time("basic_first_dec");
            end
            if (first_done != 0 && c == first_done + 1)
                check("basic_done_width", {31'h0, done}, 32'h0);
            if (done && first_done == 0) begin
                first_done = c;
                exp_q.push_back(16'h0000);
                check_time("basic_final_time");
                check("basic_final_running", {31'h0, running}, 32'h0);
                check("basic_final_show_t", {31'h0, show_t}, 32'h0);
            end
        end
        check("basic_done_cycle", first_done, 32'd20);

        // Borrow chains.
        do_load(16'h1000);
        do_start();
        repeat (4) step();
        exp_q.push_back(16'h0959);
        check_time("borrow_1000");
        do_cancel();
        do_load(16'h0100);
        do_start();
        repeat (4) step();
        exp_q.push_back(16'h0059);
        check_time("borrow_0100");
        do_cancel();

        // Pause with prescaler at 2, resume completes the remaining count.
        do_load(16'h0010);
        do_start();
        repeat (4) step();
        exp_q.push_back(16'h0009);
        check_time("pause_first_tick");
        repeat (2) step();
        do_pause();
        check("pause_running", {31'h0, running}, 32'h0);
        check("pause_show_t", {31'h0, show_t}, 32'h1);
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (running) saw_done = 1'b1;
        end
        check("pause_hold_running", {31'h0, saw_done}, 32'h0);
        exp_q.push_back(16'h0009);
        check_time("pause_hold_time");
        do_start();
        check("resume_running", {31'h0, running}, 32'h1);
        step();
        exp_q.push_back(16'h0009);
        check_time("resume_plus1");
        step();
        exp_q.push_back(16'h0008);
        check_time("resume_plus2");

        // Door interlock.
        door_open = 1'b1;
        step();
        check("door_pause_running", {31'h0, running}, 32'h0);
        check("door_pause_show_t", {31'h0, show_t}, 32'h1);
        do_start();
        check("door_start_ignored", {31'h0, running}, 32'h0);
        door_open = 1'b0;
        step();
        check("door_closed_still_paused", {31'h0, running}, 32'h0);
        do_cancel();

        // Load ignored in RUN; zero time cannot start; door blocks start from IDLE.
        do_load(16'h0020);
        do_start();
        do_load(16'h0500);
        exp_q.push_back(16'h0020);
        check_time("load_in_run");
        check("load_in_run_running", {31'h0, running}, 32'h1);
        do_cancel();
        do_load(16'h0000);
        do_start();
        check("zero_start_running", {31'h0, running}, 32'h0);
        check("zero_start_show_t", {31'h0, show_t}, 32'h0);
        do_load(16'h0001);
        door_open = 1'b1;
        do_start();
        check("door_idle_start", {31'h0, running}, 32'h0);
        door_open = 1'b0;
        do_cancel();

        // Start coincident with a tick: net +29 s.
        do_load(16'h0010);
        do_start();
        repeat (3) step();
        do_start();
        exp_q.push_back(16'h0039);
        check_time("tick_plus_add");
        do_cancel();

        // Cancel mid-run: cleared, no done pulse.
        do_load(16'h0030);
        do_start();
        step();
        do_cancel();
        exp_q.push_back(16'h0000);
        check_time("cancel_time");
        check("cancel_running", {31'h0, running}, 32'h0);
        check("cancel_show_t", {31'h0, show_t}, 32'h0);
        saw_done = done;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("cancel_no_done", {31'h0, saw_done}, 32'h0);

        // Asynchronous reset between clock edges.
        do_load(16'h0100);
        do_start();
        repeat (5) step();
        exp_q.push_back(16'h0059);
        check_time("pre_reset_time");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_time", {16'h0, time_bcd}, 32'h0);
        check("async_rst_running", {31'h0, running}, 32'h0);
        check("async_rst_show_t", {31'h0, show_t}, 32'h0);
        check("async_rst_done", {31'h0, done}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
